// File: rtl/fir_mac_sequencer.sv
// Start/busy/done sequencer for a single MAC slice computing an L-tap FIR over a D-sample buffer.
// Walks taps in convolution order, tags the last tap of each output through the DSP latency, and captures results.
module fir_mac_sequencer #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int DSP_LATENCY  = 4
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_en_o,
  output logic [H_ADDR_WIDTH-1:0] h_addr_o,
  output logic [X_ADDR_WIDTH-1:0] x_addr_o,
  output logic                    fp_load_o,
  input  logic [DATA_WIDTH-1:0]   y_i,
  input  logic                    invalid_i,
  input  logic                    overflow_i,
  input  logic                    underflow_i,
  output logic [DATA_WIDTH-1:0]   y_o,
  output logic [X_ADDR_WIDTH-1:0] y_idx_o,
  output logic                    y_valid_o,
  output logic [2:0]              err_o
);

  localparam int L = 2 ** H_ADDR_WIDTH;
  localparam int D = 2 ** X_ADDR_WIDTH;
  localparam int M = D - L + 1;
  localparam logic [H_ADDR_WIDTH-1:0] K_LAST = H_ADDR_WIDTH'(L - 1);
  localparam logic [X_ADDR_WIDTH-1:0] N_LAST = X_ADDR_WIDTH'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q;
  logic                      busy_q, done_q, rd_en_q, fp_load_q;
  logic [H_ADDR_WIDTH-1:0]   k_q, k_d;
  logic [X_ADDR_WIDTH-1:0]   n_q, n_d, x_addr_q;
  logic                      tag_last_q [DSP_LATENCY+1];
  logic [X_ADDR_WIDTH-1:0]   tag_n_q    [DSP_LATENCY+1];
  logic [DATA_WIDTH-1:0]     y_q;
  logic [X_ADDR_WIDTH-1:0]   y_idx_q;
  logic                      y_valid_q;
  logic [2:0]                err_q;
  logic                      flush, start_acc, cap;

  // Sample index for tap k of output n; one extra bit keeps the subtraction from wrapping.
  function automatic logic [X_ADDR_WIDTH-1:0] x_of(input logic [X_ADDR_WIDTH-1:0] n,
                                                   input logic [H_ADDR_WIDTH-1:0] k);
    logic [X_ADDR_WIDTH:0] sum;
    sum = {1'b0, n} + (X_ADDR_WIDTH+1)'(L - 1) - (X_ADDR_WIDTH+1)'(k);
    return sum[X_ADDR_WIDTH-1:0];
  endfunction

  assign flush     = abort_i && (state_q == RUN || state_q == DRAIN);
  assign start_acc = start_i && (state_q == IDLE);
  assign cap       = tag_last_q[DSP_LATENCY] && !flush;

  always_comb begin
    k_d = k_q + 1'b1;
    n_d = n_q;
    if (k_q == K_LAST) begin
      k_d = '0;
      n_d = n_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      fp_load_q <= 1'b1;
      k_q       <= '0;
      n_q       <= '0;
      x_addr_q  <= '0;
    end else begin
      // The k=0 operand reaches the DSP one cycle after its issue.
      fp_load_q <= !(rd_en_q && k_q == '0);
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            k_q      <= '0;
            n_q      <= '0;
            x_addr_q <= x_of('0, '0);
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            fp_load_q <= 1'b1;
          end else if (k_q == K_LAST && n_q == N_LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            k_q      <= k_d;
            n_q      <= n_d;
            x_addr_q <= x_of(n_d, k_d);
          end
        end
        DRAIN: begin
          if (abort_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            fp_load_q <= 1'b1;
          end else if (y_valid_q && y_idx_q == N_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 0 is the memory read; stages 1..DSP_LATENCY follow the DSP pipeline.
  always_ff @(posedge clk) begin
    if (rst_i || flush) begin
      for (int i = 0; i <= DSP_LATENCY; i++) begin
        tag_last_q[i] <= 1'b0;
        tag_n_q[i]    <= '0;
      end
    end else begin
      tag_last_q[0] <= rd_en_q && (k_q == K_LAST);
      tag_n_q[0]    <= n_q;
      for (int i = 1; i <= DSP_LATENCY; i++) begin
        tag_last_q[i] <= tag_last_q[i-1];
        tag_n_q[i]    <= tag_n_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      y_q       <= '0;
      y_idx_q   <= '0;
      y_valid_q <= 1'b0;
      err_q     <= '0;
    end else begin
      y_valid_q <= cap;
      if (cap) begin
        y_q     <= y_i;
        y_idx_q <= tag_n_q[DSP_LATENCY];
        err_q   <= err_q | {invalid_i, overflow_i, underflow_i};
      end
      if (start_acc) err_q <= '0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign h_addr_o  = k_q;
  assign x_addr_o  = x_addr_q;
  assign fp_load_o = fp_load_q;
  assign y_o       = y_q;
  assign y_idx_o   = y_idx_q;
  assign y_valid_o = y_valid_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: memory + MAC slice environment model, results checked against direct convolution.
// Cycle numbers are counted from the edge that accepts start (cycle 1 = first issue cycle).
module tb_fir_mac_sequencer;
  localparam int HW = 4;
  localparam int XW = 6;
  localparam int DW = 32;
  localparam int DL = 4;
  localparam int L  = 2 ** HW;
  localparam int D  = 2 ** XW;
  localparam int M  = D - L + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic          invalid_i = 1'b0, overflow_i = 1'b0, underflow_i = 1'b0;
  logic [DW-1:0] y_i;
  logic          busy_o, done_o, rd_en_o, fp_load_o, y_valid_o;
  logic [HW-1:0] h_addr_o;
  logic [XW-1:0] x_addr_o, y_idx_o;
  logic [DW-1:0] y_o;
  logic [2:0]    err_o;

  fir_mac_sequencer #(.H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW), .DATA_WIDTH(DW), .DSP_LATENCY(DL)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .h_addr_o(h_addr_o), .x_addr_o(x_addr_o),
    .fp_load_o(fp_load_o), .y_i(y_i), .invalid_i(invalid_i), .overflow_i(overflow_i),
    .underflow_i(underflow_i), .y_o(y_o), .y_idx_o(y_idx_o), .y_valid_o(y_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int tick = 0;
  int base = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) tick <= tick + 1;

  function automatic int cur_cyc();
    return tick - base + 1;
  endfunction

  // Environment: one-cycle memories feeding an integer MAC with DL cycles operand-to-result.
  logic [DW-1:0] hmem [L];
  logic [DW-1:0] xmem [D];
  logic [DW-1:0] opnd_h = '0, opnd_x = '0, acc = '0;
  logic [DW-1:0] pipe [DL-1];
  initial for (int i = 0; i < DL - 1; i++) pipe[i] = '0;
  assign y_i = pipe[DL-2];

  always @(posedge clk) begin
    if (rd_en_o) begin
      opnd_h <= hmem[h_addr_o];
      opnd_x <= xmem[x_addr_o];
    end
    acc <= fp_load_o ? acc + opnd_h * opnd_x : opnd_h * opnd_x;
    pipe[0] <= acc;
    for (int i = 1; i < DL - 1; i++) pipe[i] <= pipe[i-1];
  end

  function automatic logic [DW-1:0] ref_y(int n);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < L; k++) s = s + hmem[k] * xmem[n + L - 1 - k];
    return s;
  endfunction

  // Flags: forced value on capture cycles, optional random noise elsewhere (must be ignored).
  int ovf_n = -1;
  bit noise_en = 1'b0;
  always @(negedge clk) begin
    int c, n;
    c = cur_cyc();
    n = -1;
    if (c >= L + DL + 1 && (c - L - DL - 1) % L == 0 && (c - L - DL - 1) / L < M) n = (c - L - DL - 1) / L;
    if (n >= 0) begin
      invalid_i = 1'b0; overflow_i = (n == ovf_n); underflow_i = 1'b0;
    end else if (noise_en) begin
      invalid_i = 1'($urandom); overflow_i = 1'($urandom); underflow_i = 1'($urandom);
    end else begin
      invalid_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;
    end
  end

  typedef struct { int cyc; logic [DW-1:0] y; logic [XW-1:0] idx; } yrec_t;
  typedef struct { int cyc; logic [HW-1:0] h; logic [XW-1:0] x; } arec_t;
  yrec_t ylog[$];
  arec_t alog[$];
  int    done_log[$];
  int    load0_log[$];

  always @(negedge clk) begin
    if (y_valid_o) ylog.push_back(yrec_t'{cur_cyc(), y_o, y_idx_o});
    if (rd_en_o)   alog.push_back(arec_t'{cur_cyc(), h_addr_o, x_addr_o});
    if (done_o)    done_log.push_back(cur_cyc());
    if (!fp_load_o) load0_log.push_back(cur_cyc());
  end

  task automatic clear_logs();
    ylog.delete(); alog.delete(); done_log.delete(); load0_log.delete();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    base = tick;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic goto_cycle(int c);
    while (cur_cyc() < c) @(negedge clk);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < L; i++) hmem[i] = DW'($urandom_range(0, 1000));
    for (int i = 0; i < D; i++) xmem[i] = DW'($urandom_range(0, 1000));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o, done_o, rd_en_o, y_valid_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {busy_o, done_o, rd_en_o, y_valid_o});
    end
    total++;
    if (fp_load_o !== 1'b1) begin bad++; $display("FAIL reset_fp_load got %b want 1", fp_load_o); end
    total++;
    if ({y_o, y_idx_o} !== '0) begin bad++; $display("FAIL reset_y got y=%h idx=%0d want 0", y_o, y_idx_o); end
    total++;
    if ({h_addr_o, x_addr_o} !== '0) begin bad++; $display("FAIL reset_addr got h=%0d x=%0d want 0", h_addr_o, x_addr_o); end
    total++;
    if (err_o !== 3'b000) begin bad++; $display("FAIL reset_err got %b want 000", err_o); end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < L; i++) hmem[i] = 32'd1;
    for (int i = 0; i < D; i++) xmem[i] = DW'(i);
    clear_logs();
    do_start();
    total++;
    if (busy_o !== 1'b1 || rd_en_o !== 1'b1 || h_addr_o !== '0 || x_addr_o !== XW'(L - 1)) begin
      bad++; $display("FAIL nom_first_issue got busy=%b rd=%b h=%0d x=%0d want 1 1 0 %0d", busy_o, rd_en_o, h_addr_o, x_addr_o, L - 1);
    end
    goto_cycle(M * L + DL + 2);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL nom_busy_last got %b want 1", busy_o); end
    goto_cycle(M * L + DL + 3);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      bad++; $display("FAIL nom_done_cycle got busy=%b done=%b want 0 1", busy_o, done_o);
    end
    goto_cycle(M * L + DL + 8);
    total++;
    if (ylog.size() != M) begin bad++; $display("FAIL nom_count got %0d want %0d", ylog.size(), M); end
    for (int i = 0; i < ylog.size() && i < M; i++) begin
      total++;
      if (ylog[i].cyc != i * L + L + DL + 2 || ylog[i].idx !== XW'(i) || ylog[i].y !== DW'(16 * i + 120)) begin
        bad++;
        $display("FAIL nom_y[%0d] got cyc=%0d idx=%0d y=%0d want cyc=%0d idx=%0d y=%0d",
                 i, ylog[i].cyc, ylog[i].idx, ylog[i].y, i * L + L + DL + 2, i, 16 * i + 120);
      end
    end
    total++;
    if (done_log.size() != 1 || done_log[0] != M * L + DL + 3) begin
      bad++; $display("FAIL nom_done got n=%0d first=%0d want 1 at %0d", done_log.size(),
                      (done_log.size() > 0) ? done_log[0] : -1, M * L + DL + 3);
    end
    total++;
    if (alog.size() != M * L) begin bad++; $display("FAIL nom_issue_count got %0d want %0d", alog.size(), M * L); end
    for (int i = 0; i < alog.size() && i < M * L; i++) begin
      total++;
      if (alog[i].cyc != 1 + i || alog[i].h !== HW'(i % L) || alog[i].x !== XW'(i / L + L - 1 - i % L)) begin
        bad++;
        $display("FAIL nom_addr[%0d] got cyc=%0d h=%0d x=%0d want cyc=%0d h=%0d x=%0d",
                 i, alog[i].cyc, alog[i].h, alog[i].x, 1 + i, i % L, i / L + L - 1 - i % L);
      end
    end
    total++;
    if (load0_log.size() != M) begin bad++; $display("FAIL nom_load_count got %0d want %0d", load0_log.size(), M); end
    for (int i = 0; i < load0_log.size() && i < M; i++) begin
      total++;
      if (load0_log[i] != 2 + i * L) begin
        bad++; $display("FAIL nom_load[%0d] got cyc=%0d want %0d", i, load0_log[i], 2 + i * L);
      end
    end
  endtask

  task automatic test_start_while_busy();
    rand_mem();
    noise_en = 1'b1;
    clear_logs();
    do_start();
    goto_cycle(100); start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    goto_cycle(500); start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    goto_cycle(M * L + DL + 8);
    noise_en = 1'b0;
    total++;
    if (ylog.size() != M) begin bad++; $display("FAIL busy_count got %0d want %0d", ylog.size(), M); end
    for (int i = 0; i < ylog.size() && i < M; i++) begin
      total++;
      if (ylog[i].cyc != i * L + L + DL + 2 || ylog[i].idx !== XW'(i) || ylog[i].y !== ref_y(i)) begin
        bad++;
        $display("FAIL busy_y[%0d] got cyc=%0d idx=%0d y=%0d want cyc=%0d idx=%0d y=%0d",
                 i, ylog[i].cyc, ylog[i].idx, ylog[i].y, i * L + L + DL + 2, i, ref_y(i));
      end
    end
    total++;
    if (done_log.size() != 1 || done_log[0] != M * L + DL + 3) begin
      bad++; $display("FAIL busy_done got n=%0d want 1 at %0d", done_log.size(), M * L + DL + 3);
    end
    total++;
    if (err_o !== 3'b000) begin bad++; $display("FAIL busy_err_noise got %b want 000", err_o); end
  endtask

  task automatic test_abort();
    rand_mem();
    clear_logs();
    do_start();
    goto_cycle(300); abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
    total++;
    if (rd_en_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL abort_idle got rd=%b busy=%b want 0 0", rd_en_o, busy_o);
    end
    goto_cycle(310);
    total++;
    if (ylog.size() != 18 || done_log.size() != 0 || alog[alog.size()-1].cyc != 300) begin
      bad++; $display("FAIL abort_quiet got y=%0d done=%0d last_issue=%0d want 18 0 300",
                      ylog.size(), done_log.size(), alog[alog.size()-1].cyc);
    end
    clear_logs();
    do_start();
    goto_cycle(M * L + DL + 8);
    total++;
    if (ylog.size() != M || done_log.size() != 1) begin
      bad++; $display("FAIL abort_restart got y=%0d done=%0d want %0d 1", ylog.size(), done_log.size(), M);
    end
    for (int i = 0; i < ylog.size() && i < M; i++) begin
      total++;
      if (ylog[i].idx !== XW'(i) || ylog[i].y !== ref_y(i)) begin
        bad++; $display("FAIL abort_restart_y[%0d] got idx=%0d y=%0d want %0d %0d", i, ylog[i].idx, ylog[i].y, i, ref_y(i));
      end
    end
  endtask

  task automatic test_flags();
    rand_mem();
    ovf_n = 5; noise_en = 1'b1;
    clear_logs();
    do_start();
    goto_cycle(5 * L + L + DL + 3);
    total++;
    if (err_o !== 3'b010) begin bad++; $display("FAIL flag_after_capture got %b want 010", err_o); end
    goto_cycle(M * L + DL + 20);
    total++;
    if (err_o !== 3'b010 || done_log.size() != 1) begin
      bad++; $display("FAIL flag_sticky got err=%b done=%0d want 010 1", err_o, done_log.size());
    end
    ovf_n = -1;
    do_start();
    total++;
    if (err_o !== 3'b000) begin bad++; $display("FAIL flag_clear_on_start got %b want 000", err_o); end
    goto_cycle(M * L + DL + 8);
    noise_en = 1'b0;
    total++;
    if (err_o !== 3'b000) begin bad++; $display("FAIL flag_clean_run got %b want 000", err_o); end
  endtask

  task automatic test_reset_drain();
    rand_mem();
    ovf_n = 5;
    clear_logs();
    do_start();
    goto_cycle(788);
    total++;
    if (err_o !== 3'b010) begin bad++; $display("FAIL rstd_err_before got %b want 010", err_o); end
    rst_i = 1'b1; @(negedge clk); rst_i = 1'b0;
    ovf_n = -1;
    total++;
    if ({busy_o, done_o, rd_en_o, y_valid_o, fp_load_o, err_o} !== {5'b00001, 3'b000} || {y_o, y_idx_o, h_addr_o, x_addr_o} !== '0) begin
      bad++; $display("FAIL rstd_values got busy=%b done=%b rd=%b v=%b load=%b err=%b y=%h idx=%0d h=%0d x=%0d want reset",
                      busy_o, done_o, rd_en_o, y_valid_o, fp_load_o, err_o, y_o, y_idx_o, h_addr_o, x_addr_o);
    end
    goto_cycle(800);
    total++;
    if (ylog.size() != M - 1 || done_log.size() != 0) begin
      bad++; $display("FAIL rstd_quiet got y=%0d done=%0d want %0d 0", ylog.size(), done_log.size(), M - 1);
    end
  endtask

  task automatic test_back_to_back();
    rand_mem();
    clear_logs();
    start_i = 1'b1;
    @(posedge clk); #1;
    base = tick;
    goto_cycle(M * L + DL + 4);
    total++;
    if (rd_en_o !== 1'b0 || busy_o !== 1'b0 || done_log.size() != 1 || ylog.size() != M) begin
      bad++; $display("FAIL b2b_gap got rd=%b busy=%b done=%0d y=%0d want 0 0 1 %0d", rd_en_o, busy_o, done_log.size(), ylog.size(), M);
    end
    @(posedge clk); #1;
    base = tick;
    clear_logs();
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if (rd_en_o !== 1'b1 || busy_o !== 1'b1 || h_addr_o !== '0 || x_addr_o !== XW'(L - 1)) begin
      bad++; $display("FAIL b2b_restart got rd=%b busy=%b h=%0d x=%0d want 1 1 0 %0d", rd_en_o, busy_o, h_addr_o, x_addr_o, L - 1);
    end
    goto_cycle(M * L + DL + 8);
    total++;
    if (ylog.size() != M || done_log.size() != 1 || done_log[0] != M * L + DL + 3) begin
      bad++; $display("FAIL b2b_second_run got y=%0d done=%0d want %0d 1", ylog.size(), done_log.size(), M);
    end
    total++;
    if (ylog.size() > 0 && ylog[ylog.size()-1].y !== ref_y(M - 1)) begin
      bad++; $display("FAIL b2b_last_y got %0d want %0d", ylog[ylog.size()-1].y, ref_y(M - 1));
    end
  endtask

  task automatic test_abort_corner();
    clear_logs();
    abort_i = 1'b1;
    do_start();
    abort_i = 1'b0;
    total++;
    if (rd_en_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL corner_start_wins got rd=%b busy=%b want 1 1", rd_en_o, busy_o);
    end
    goto_cycle(M * L + DL + 3);
    abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
    goto_cycle(M * L + DL + 8);
    total++;
    if (done_log.size() != 1 || done_log[0] != M * L + DL + 3 || ylog.size() != M || busy_o !== 1'b0) begin
      bad++; $display("FAIL corner_abort_in_done got done=%0d y=%0d busy=%b want 1 %0d 0", done_log.size(), ylog.size(), busy_o, M);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_start_while_busy();
    test_abort();
    test_flags();
    test_reset_drain();
    test_back_to_back();
    test_abort_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencing controller for the FIR filter's single floating-point DSP58 multiply-accumulate slice. On a start pulse it walks the coefficient and sample memories in convolution order and drives the slice's accumulate/load mode bit. It captures every completed output sample together with its index, and accumulates sticky FP exception flags. It sits between the coefficient/sample memory block and the DSP58 wrapper, replacing free-running counter control with a start/busy/done handshake.

## Interface

Parameters:
- H_ADDR_WIDTH, 4, coefficient address width; filter length L = 2**H_ADDR_WIDTH
- X_ADDR_WIDTH, 6, sample address width; sample depth D = 2**X_ADDR_WIDTH; D > L required
- DATA_WIDTH, 32, FP32 word width
- DSP_LATENCY, 4, cycles from operands at DSP inputs to accumulated result on y_i (≥1)

Derived: M = D − L + 1 outputs per run (49 at defaults).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request a run; honoured only in IDLE
- abort_i  in  1  synchronous cancel of an active run
- busy_o  out  1  high from first issue cycle through last result capture
- done_o  out  1  one-cycle pulse after the last result
- rd_en_o  out  1  memory read enable
- h_addr_o  out  H_ADDR_WIDTH  coefficient address
- x_addr_o  out  X_ADDR_WIDTH  sample address
- fp_load_o  out  1  to DSP fpopmode: 0 = load (first tap), 1 = accumulate; aligned with operand data
- y_i  in  DATA_WIDTH  DSP accumulated result
- invalid_i, overflow_i, underflow_i  in  1 each  DSP FP flags, aligned with y_i
- y_o  out  DATA_WIDTH  captured output sample
- y_idx_o  out  X_ADDR_WIDTH  output index n of y_o
- y_valid_o  out  1  one-cycle strobe, y_o/y_idx_o valid
- err_o  out  3  sticky {invalid, overflow, underflow}

## Operation

- States:
  - IDLE: entered on reset.
  - RUN: entered from IDLE on start_i. Issues M·L read cycles, then goes to DRAIN.
  - DRAIN: waits until the last result is captured, then goes to DONE.
  - DONE: lasts one cycle (done_o=1), then returns to IDLE.
- Issue order in RUN:
  - Outer loop n = 0..M−1; inner loop k = 0..L−1.
  - h_addr_o = k, x_addr_o = n + L − 1 − k, rd_en_o = 1 each cycle.
  - No gap between outputs.
- Memory read latency is 1 cycle. A delay line of depth 1 carries first-tap, last-tap and n alongside the issue stream.
  - fp_load_o = 1 except in the cycle the k=0 operand is at the DSP, where it is 0.
- Result tag pipeline: the last-tap marker and n are delayed a further DSP_LATENCY cycles.
  - When the delayed marker is set, y_i and the flags are registered into y_o/y_idx_o, and y_valid_o pulses next cycle.
  - err_o |= flags on each capture.
- err_o is cleared on the cycle start_i is accepted. It holds after done, until the next start or reset.
- start_i outside IDLE is ignored, with no queuing.
- abort_i in RUN or DRAIN:
  - Next cycle: state = IDLE, rd_en_o = 0, tag pipelines flushed.
  - No further y_valid_o, no done_o; err_o retained.
- abort_i and start_i together in IDLE: start wins (abort has no effect in IDLE).
- abort_i in DONE: done still completes.
- rst_i mid-run behaves like abort, except err_o is cleared.
- Address arithmetic:
  - x_addr_o is computed in X_ADDR_WIDTH+1 bits, then truncated.
  - The range is guaranteed 0..D−1 by construction, with no wrap.
  - The n counter counts to M−1 and k wraps at L−1.

## Timing

- Reset values: all outputs 0 (busy_o, done_o, rd_en_o, y_valid_o, y_o, y_idx_o, h_addr_o, x_addr_o, err_o); fp_load_o = 1.
- start_i is sampled at edge E0. The first issue cycle is cycle 1, with h=0, x=L−1 and busy_o rising.
- The issue for output n, tap k occurs in cycle 1 + nL + k. Its operand reaches the DSP one cycle later.
- y_valid_o for output n is high in cycle nL + L + DSP_LATENCY + 2.
  - At defaults: cycle 16n + 22, so the first is cycle 22 and the last is cycle 790.
- busy_o falls after the last y_valid_o cycle. done_o pulses in cycle M·L + DSP_LATENCY + 3 (791 at defaults).
- Earliest accepted restart: start_i sampled high during done_o is ignored; the first honoured restart is in the following cycle.
- Throughput is 1 tap/cycle, and consecutive y_valid_o pulses are exactly L cycles apart.

## Test plan

- Nominal run with defaults, memories of h=1.0 and x[i]=i: 49 y_valid_o pulses at cycles 22, 38, …, 790. Each y_o = Σ(n..n+15) = 16n+120 in FP32, with y_idx_o = n and done_o at cycle 791.
- Address/mode check: log h_addr_o/x_addr_o for n=0 (0/15 … 15/0) and n=48 (0/63 … 15/48). fp_load_o = 0 exactly once per 16 cycles, at cycles 2, 18, ….
- Start while busy: pulse start_i at cycles 100 and 500. No effect; pulse count and done cycle unchanged.
- Abort at cycle 300: rd_en_o = 0 and state IDLE at cycle 301. No y_valid_o after 301 and no done_o. A new start at 310 runs cleanly to 49 outputs.
- Flags: force overflow_i only at capture n=5, giving err_o = 3'b010 sticky through done. A subsequent start_i clears it to 0.
- Reset mid-DRAIN (cycle 788): all outputs reach reset values next cycle, with no y_valid_o at 790 and no done_o.
